// File: rtl/detector_eventos_boton.sv
// Button event detector: turns a debounced level into press, release,
// long-press and auto-repeat pulses, and keeps a wrapping press count.
module detector_eventos_boton #(
    parameter int CICLOS_LARGO      = 50,
    parameter int CICLOS_REPETICION = 10,
    parameter int ANCHO_CONTADOR    = 16
) (
    input  logic       reloj,
    input  logic       reinicio,
    input  logic       botonFiltrado,
    output logic       pulsoPresion,
    output logic       pulsoSoltar,
    output logic       pulsoLargo,
    output logic       pulsoRepeticion,
    output logic       estaPresionado,
    output logic [7:0] cuentaPresiones
);

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        PRESIONADO = 2'd1,
        REPETIR    = 2'd2
    } estado_t;

    localparam logic [ANCHO_CONTADOR-1:0] CERO_C  = '0;
    localparam logic [ANCHO_CONTADOR-1:0] UNO_C   = ANCHO_CONTADOR'(1);
    localparam logic [ANCHO_CONTADOR-1:0] LARGO_C = ANCHO_CONTADOR'(CICLOS_LARGO);
    localparam logic [ANCHO_CONTADOR-1:0] REPET_C = ANCHO_CONTADOR'(CICLOS_REPETICION);

    estado_t                   estado_r, estado_s;
    logic [ANCHO_CONTADOR-1:0] contador_r, contador_s, contador_mas_uno_s;
    logic [7:0]                cuenta_r, cuenta_s;
    logic                      pulso_presion_r, pulso_presion_s;
    logic                      pulso_soltar_r, pulso_soltar_s;
    logic                      pulso_largo_r, pulso_largo_s;
    logic                      pulso_repeticion_r, pulso_repeticion_s;
    logic                      esta_presionado_r;

    assign contador_mas_uno_s = contador_r + UNO_C;

    // Next-state, hold counter and pulse decode; a low sample always wins over thresholds.
    always_comb begin
        estado_s           = estado_r;
        contador_s         = contador_r;
        cuenta_s           = cuenta_r;
        pulso_presion_s    = 1'b0;
        pulso_soltar_s     = 1'b0;
        pulso_largo_s      = 1'b0;
        pulso_repeticion_s = 1'b0;
        case (estado_r)
            REPOSO: begin
                if (botonFiltrado) begin
                    estado_s        = PRESIONADO;
                    contador_s      = UNO_C;
                    cuenta_s        = cuenta_r + 8'd1;
                    pulso_presion_s = 1'b1;
                end else begin
                    contador_s = CERO_C;
                end
            end
            PRESIONADO: begin
                if (!botonFiltrado) begin
                    estado_s       = REPOSO;
                    contador_s     = CERO_C;
                    pulso_soltar_s = 1'b1;
                end else if (contador_mas_uno_s == LARGO_C) begin
                    estado_s      = REPETIR;
                    contador_s    = CERO_C;
                    pulso_largo_s = 1'b1;
                end else begin
                    contador_s = contador_mas_uno_s;
                end
            end
            REPETIR: begin
                if (!botonFiltrado) begin
                    estado_s       = REPOSO;
                    contador_s     = CERO_C;
                    pulso_soltar_s = 1'b1;
                end else if (contador_mas_uno_s == REPET_C) begin
                    contador_s         = CERO_C;
                    pulso_repeticion_s = 1'b1;
                end else begin
                    contador_s = contador_mas_uno_s;
                end
            end
            default: begin
                estado_s   = REPOSO;
                contador_s = CERO_C;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge reloj) begin
        if (reinicio) begin
            estado_r           <= REPOSO;
            contador_r         <= CERO_C;
            cuenta_r           <= 8'd0;
            pulso_presion_r    <= 1'b0;
            pulso_soltar_r     <= 1'b0;
            pulso_largo_r      <= 1'b0;
            pulso_repeticion_r <= 1'b0;
            esta_presionado_r  <= 1'b0;
        end else begin
            estado_r           <= estado_s;
            contador_r         <= contador_s;
            cuenta_r           <= cuenta_s;
            pulso_presion_r    <= pulso_presion_s;
            pulso_soltar_r     <= pulso_soltar_s;
            pulso_largo_r      <= pulso_largo_s;
            pulso_repeticion_r <= pulso_repeticion_s;
            esta_presionado_r  <= (estado_s != REPOSO);
        end
    end

    assign pulsoPresion    = pulso_presion_r;
    assign pulsoSoltar     = pulso_soltar_r;
    assign pulsoLargo      = pulso_largo_r;
    assign pulsoRepeticion = pulso_repeticion_r;
    assign estaPresionado  = esta_presionado_r;
    assign cuentaPresiones = cuenta_r;

endmodule

// File: tb/tb_detector_eventos_boton.sv
// Bench for detector_eventos_boton: directed scenarios plus random hold/release
// runs, checked every cycle against a run-length reference model.
module tb_detector_eventos_boton;

    localparam int L = 50;
    localparam int R = 10;

    logic       reloj = 1'b0;
    logic       reinicio = 1'b1;
    logic       boton = 1'b0;
    logic       pulso_presion, pulso_soltar, pulso_largo, pulso_repeticion, esta_presionado;
    logic [7:0] cuenta;

    int total = 0;
    int bad = 0;

    // model state: length of the current high run and press count
    int run_m = 0;
    int cuenta_m = 0;
    logic ep_m, es_m, el_m, er_m;

    // DUT pulse tallies for scenario-level checks
    int n_presion = 0, n_soltar = 0, n_largo = 0, n_rep = 0;

    detector_eventos_boton #(
        .CICLOS_LARGO(L),
        .CICLOS_REPETICION(R),
        .ANCHO_CONTADOR(16)
    ) dut (
        .reloj(reloj),
        .reinicio(reinicio),
        .botonFiltrado(boton),
        .pulsoPresion(pulso_presion),
        .pulsoSoltar(pulso_soltar),
        .pulsoLargo(pulso_largo),
        .pulsoRepeticion(pulso_repeticion),
        .estaPresionado(esta_presionado),
        .cuentaPresiones(cuenta)
    );

    always #5 reloj = ~reloj;

    task automatic verificar(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic limpiar_tallies();
        n_presion = 0; n_soltar = 0; n_largo = 0; n_rep = 0;
    endtask

    // one clock edge: drive inputs, advance the model, check every output
    task automatic paso(input logic b, input logic r);
        boton = b;
        reinicio = r;
        @(posedge reloj);
        ep_m = 1'b0; es_m = 1'b0; el_m = 1'b0; er_m = 1'b0;
        if (r) begin
            run_m = 0;
            cuenta_m = 0;
        end else if (b) begin
            run_m++;
            ep_m = (run_m == 1);
            el_m = (run_m == L);
            er_m = (run_m > L) && (((run_m - L) % R) == 0);
            if (ep_m) cuenta_m = (cuenta_m + 1) % 256;
        end else begin
            es_m = (run_m > 0);
            run_m = 0;
        end
        #1;
        verificar("presion", int'(pulso_presion), int'(ep_m));
        verificar("soltar", int'(pulso_soltar), int'(es_m));
        verificar("largo", int'(pulso_largo), int'(el_m));
        verificar("repeticion", int'(pulso_repeticion), int'(er_m));
        verificar("esta_presionado", int'(esta_presionado), (run_m > 0) ? 1 : 0);
        verificar("cuenta", int'(cuenta), cuenta_m);
        verificar("un_pulso", int'(pulso_presion) + int'(pulso_soltar) + int'(pulso_largo)
                  + int'(pulso_repeticion) > 1 ? 1 : 0, 0);
        n_presion += int'(pulso_presion);
        n_soltar  += int'(pulso_soltar);
        n_largo   += int'(pulso_largo);
        n_rep     += int'(pulso_repeticion);
    endtask

    initial begin
        // 1: reset then idle
        paso(1'b0, 1'b1);
        paso(1'b0, 1'b1);
        limpiar_tallies();
        for (int i = 0; i < 20; i++) paso(1'b0, 1'b0);
        verificar("idle_pulsos", n_presion + n_soltar + n_largo + n_rep, 0);

        // 2: short press of 5 cycles
        limpiar_tallies();
        for (int i = 0; i < 5; i++) paso(1'b1, 1'b0);
        paso(1'b0, 1'b0);
        paso(1'b0, 1'b0);
        verificar("corta_presion", n_presion, 1);
        verificar("corta_soltar", n_soltar, 1);
        verificar("corta_largo", n_largo, 0);
        verificar("corta_cuenta", int'(cuenta), 1);

        // 3: hold 80 cycles
        limpiar_tallies();
        for (int i = 0; i < 80; i++) paso(1'b1, 1'b0);
        paso(1'b0, 1'b0);
        paso(1'b0, 1'b0);
        verificar("larga_largo", n_largo, 1);
        verificar("larga_rep", n_rep, 3);
        verificar("larga_soltar", n_soltar, 1);

        // 4: release exactly on edge L
        limpiar_tallies();
        for (int i = 0; i < L - 1; i++) paso(1'b1, 1'b0);
        paso(1'b0, 1'b0);
        verificar("borde_largo", n_largo, 0);
        verificar("borde_soltar", n_soltar, 1);
        verificar("borde_reposo", int'(esta_presionado), 0);

        // 5: wrap of the press counter
        paso(1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            paso(1'b1, 1'b0);
            paso(1'b0, 1'b0);
        end
        verificar("wrap_cero", int'(cuenta), 0);
        paso(1'b1, 1'b0);
        paso(1'b0, 1'b0);
        verificar("wrap_uno", int'(cuenta), 1);

        // 6: reset mid long hold with the button still high
        for (int i = 0; i < 60; i++) paso(1'b1, 1'b0);
        paso(1'b1, 1'b1);
        verificar("rst_esta", int'(esta_presionado), 0);
        limpiar_tallies();
        paso(1'b1, 1'b0);
        verificar("rst_presion", n_presion, 1);
        verificar("rst_cuenta", int'(cuenta), 1);
        for (int i = 0; i < 5; i++) paso(1'b1, 1'b0);
        paso(1'b0, 1'b0);

        // random hold/release runs with occasional resets
        for (int k = 0; k < 60; k++) begin
            int alto, bajo;
            alto = $urandom_range(130, 1);
            bajo = $urandom_range(4, 1);
            for (int i = 0; i < alto; i++) paso(1'b1, ($urandom_range(199, 0) == 0));
            for (int i = 0; i < bajo; i++) paso(1'b0, ($urandom_range(49, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
